// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between an LSU (master) and the data memory controller (slave).
// Address width covers exactly DEPTH words of WORD_SIZE bits, byte addressed.
interface data_mem_ctrl_if #(
    parameter int DEPTH     = 1024,
    parameter int WORD_SIZE = 32
);
    localparam int AW = $clog2(DEPTH * WORD_SIZE / 8);

    logic                 req;
    logic                 we;
    logic [2:0]           funct3;
    logic [AW-1:0]        addr;
    logic [WORD_SIZE-1:0] dataIn;
    logic                 ready;
    logic                 rvalid;
    logic [WORD_SIZE-1:0] dataOut;
    logic                 err;

    modport master (
        output req, we, funct3, addr, dataIn,
        input  ready, rvalid, dataOut, err
    );

    modport slave (
        input  req, we, funct3, addr, dataIn,
        output ready, rvalid, dataOut, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RISC-V data memory, byte-lane stores and sign/zero-extending loads; DMEM_MISALIGN_TRAP_EN turns misaligned accesses into faults.
// Stores complete next cycle at full rate; loads complete READ_LATENCY edges after acceptance with ready low meanwhile (req is never queued).
module data_mem_ctrl #(
    parameter int DEPTH        = 1024,
    parameter int WORD_SIZE    = 32,
    parameter int READ_LATENCY = 1
) (
    input logic            clk,
    input logic            rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int NB  = WORD_SIZE / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH * NB);
    localparam int IW  = AW - OFF;

    if (WORD_SIZE != 32 && WORD_SIZE != 64) begin : g_bad_word_size
        $error("data_mem_ctrl: WORD_SIZE must be 32 or 64");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_mem_ctrl: READ_LATENCY must be 1..4");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (WORD_SIZE == 64);
            3'b100, 3'b101:         ok = !st;
            3'b110:                 ok = !st && (WORD_SIZE == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [OFF-1:0] size_mask(input logic [1:0] sz);
        logic [OFF-1:0] m;
        case (sz)
            2'd0:    m = '0;
            2'd1:    m = OFF'(1);
            2'd2:    m = OFF'(3);
            default: m = OFF'(7);
        endcase
        return m;
    endfunction

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_t               state, state_nxt;
    logic [1:0]           cnt, cnt_nxt;
    logic                 rvalid_q, rvalid_nxt;
    logic                 err_q, err_nxt;
    logic [WORD_SIZE-1:0] dout_q, dout_nxt;

    logic [IW-1:0]        ld_idx;
    logic [OFF-1:0]       ld_off;
    logic [2:0]           ld_f3;
    logic                 ld_fault;

    logic                 accept;
    logic                 req_fault;
    logic [OFF-1:0]       req_off, st_off;
    logic [IW-1:0]        req_idx;
    logic [NB-1:0]        st_base, st_mask;
    logic [WORD_SIZE-1:0] st_data;
    logic [WORD_SIZE-1:0] ld_word, ld_sh, ld_ext;

    assign accept  = bus.req && (state == IDLE);
    assign req_off = bus.addr[OFF-1:0];
    assign req_idx = bus.addr[AW-1:OFF];

    always_comb begin
        req_fault = !f3_legal(bus.we, bus.funct3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (|(req_off & size_mask(bus.funct3[1:0]))) req_fault = 1'b1;
`endif
        // Without the trap, sub-size offset bits are simply dropped.
        st_off = req_off & ~size_mask(bus.funct3[1:0]);
        case (bus.funct3[1:0])
            2'd0:    st_base = NB'(1);
            2'd1:    st_base = NB'(3);
            2'd2:    st_base = NB'(15);
            default: st_base = NB'(255);
        endcase
        st_mask = st_base << st_off;
        st_data = bus.dataIn << {st_off, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (accept && bus.we && !req_fault) begin
            for (int b = 0; b < NB; b++) begin
                if (st_mask[b]) mem[req_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // Array read happens at the completing edge, so a store one cycle earlier is visible.
    always_comb begin
        ld_word = mem[ld_idx];
        ld_sh   = ld_word >> {ld_off, 3'b000};
        case (ld_f3)
            3'b000:  ld_ext = WORD_SIZE'($signed(ld_sh[7:0]));
            3'b001:  ld_ext = WORD_SIZE'($signed(ld_sh[15:0]));
            3'b010:  ld_ext = WORD_SIZE'($signed(ld_sh[31:0]));
            3'b100:  ld_ext = WORD_SIZE'(ld_sh[7:0]);
            3'b101:  ld_ext = WORD_SIZE'(ld_sh[15:0]);
            3'b110:  ld_ext = WORD_SIZE'(ld_sh[31:0]);
            default: ld_ext = ld_sh;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rvalid_nxt = 1'b0;
        err_nxt    = 1'b0;
        dout_nxt   = dout_q;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bus.we) begin
                        rvalid_nxt = 1'b1;
                        err_nxt    = req_fault;
                        if (req_fault) dout_nxt = '0;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = 2'(READ_LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt == 2'd0) begin
                    state_nxt  = IDLE;
                    rvalid_nxt = 1'b1;
                    err_nxt    = ld_fault;
                    dout_nxt   = ld_fault ? '0 : ld_ext;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
            ld_idx   <= '0;
            ld_off   <= '0;
            ld_f3    <= 3'b000;
            ld_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rvalid_q <= rvalid_nxt;
            err_q    <= err_nxt;
            dout_q   <= dout_nxt;
            if (accept && !bus.we) begin
                ld_idx   <= req_idx;
                ld_off   <= st_off;
                ld_f3    <= bus.funct3;
                ld_fault <= req_fault;
            end
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.rvalid  = rvalid_q;
    assign bus.err     = err_q;
    assign bus.dataOut = dout_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl (32-bit words, READ_LATENCY=3) against a byte-array reference model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int WS    = 32;
    localparam int RL    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DEPTH(DEPTH), .WORD_SIZE(WS)) bus ();

    data_mem_ctrl #(.DEPTH(DEPTH), .WORD_SIZE(WS), .READ_LATENCY(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic        ld;
        logic [31:0] val;
    } exp_t;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          ready_cyc = 0;
    bit          mon_en    = 1'b0;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_dout  = '0;
    exp_t        exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input logic w, input logic [2:0] f3);
        if (w) return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Apply an accepted access to the byte-level model and queue the completion it must produce.
    task automatic model_accept(input logic w, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        int   base;
        bit   f;
        n = acc_bytes(f3);
        f = !is_legal(w, f3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (int'(a) % n != 0) f = 1'b1;
        base = int'(a);
`else
        base = int'(a) - (int'(a) % n);
`endif
        e.err = f;
        e.ld  = !w;
        e.val = '0;
        if (w) begin
            if (!f) for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
            e.cyc = cyc + 1;
        end else begin
            if (!f) begin
                for (int i = 0; i < n; i++) e.val[8*i +: 8] = ref_mem[base + i];
                if (!f3[2] && n < 4 && e.val[8*n - 1]) begin
                    for (int i = n; i < 4; i++) e.val[8*i +: 8] = 8'hFF;
                end
            end
            e.cyc     = cyc + 1 + RL;
            ready_cyc = e.cyc;
        end
        exp_q.push_back(e);
    endtask

    // Present a request at a falling edge and hold it until accepted; returns just after the accepting edge.
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.dataIn = d;
        while (!bus.ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.ready) begin
            errors++;
            $display("FAIL accept_timeout: ready stayed %b, required 1", bus.ready);
            bus.req = 1'b0;
        end else begin
            model_accept(w, f3, a, d);
            @(posedge clk);
            #1 bus.req = 1'b0;
        end
    endtask

    task automatic access_wait(input logic w, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                               output logic [31:0] dout, output logic e, output int lat);
        do_access(w, f3, a, d);
        lat = 0;
        while (!bus.rvalid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rvalid_seen", bus.rvalid, 1);
        dout = bus.dataOut;
        e    = bus.err;
    endtask

    // Cycle-by-cycle compare of every output against the model.
    bit          hit;
    logic        exp_err;
    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                hit     = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                exp_err = hit ? exp_q[0].err : 1'b0;
                if (hit) begin
                    if (exp_q[0].ld || exp_q[0].err) exp_dout = exp_q[0].val;
                    void'(exp_q.pop_front());
                end
                chk("ready",   bus.ready,   32'(cyc >= ready_cyc));
                chk("rvalid",  bus.rvalid,  32'(hit));
                chk("err",     bus.err,     32'(exp_err));
                chk("dataOut", bus.dataOut, exp_dout);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] dv;
    logic        ev;
    int          lat;
    int          rv_cnt;
    logic        rw;
    logic [2:0]  rf3;

    initial begin : stim
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = '0; bus.dataIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   bus.ready,   1);
        chk("rst_rvalid",  bus.rvalid,  0);
        chk("rst_err",     bus.err,     0);
        chk("rst_dataOut", bus.dataOut, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 64; i++) do_access(1'b1, 3'b010, 12'(i * 4), $urandom);

        access_wait(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, dv, ev, lat);
        chk("sw_err", ev, 0);
        chk("sw_lat", lat, 0);
        access_wait(1'b0, 3'b010, 12'h010, 32'h0, dv, ev, lat);
        chk("lw_data", dv, 32'hDEADBEEF);
        chk("lw_lat", lat, RL);

        access_wait(1'b1, 3'b010, 12'h020, 32'h0, dv, ev, lat);
        access_wait(1'b1, 3'b000, 12'h021, 32'h0000_0080, dv, ev, lat);
        access_wait(1'b0, 3'b000, 12'h021, 32'h0, dv, ev, lat);
        chk("lb_data", dv, 32'hFFFFFF80);
        access_wait(1'b0, 3'b100, 12'h021, 32'h0, dv, ev, lat);
        chk("lbu_data", dv, 32'h00000080);
        access_wait(1'b0, 3'b101, 12'h020, 32'h0, dv, ev, lat);
        chk("lhu_data", dv, 32'h00008000);

        access_wait(1'b1, 3'b010, 12'h030, 32'hAAAAAAAA, dv, ev, lat);
        access_wait(1'b1, 3'b001, 12'h032, 32'h0000_1234, dv, ev, lat);
        access_wait(1'b0, 3'b010, 12'h030, 32'h0, dv, ev, lat);
        chk("sh_merge", dv, 32'h1234AAAA);

        access_wait(1'b0, 3'b111, 12'h030, 32'h0, dv, ev, lat);
        chk("undef_ld_err", ev, 1);
        chk("undef_ld_data", dv, 0);
        access_wait(1'b1, 3'b111, 12'h030, 32'h5555_5555, dv, ev, lat);
        chk("undef_st_err", ev, 1);
        access_wait(1'b0, 3'b010, 12'h030, 32'h0, dv, ev, lat);
        chk("undef_no_write", dv, 32'h1234AAAA);

        access_wait(1'b0, 3'b010, 12'h013, 32'h0, dv, ev, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign_err", ev, 1);
        chk("misalign_data", dv, 0);
`else
        chk("misalign_err", ev, 0);
        chk("misalign_data", dv, 32'hDEADBEEF);
`endif
        chk("misalign_lat", lat, RL);

        do_access(1'b0, 3'b010, 12'h010, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        ready_cyc = 0;
        exp_dout  = '0;
        #1;
        chk("midrst_ready", bus.ready, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        rv_cnt = 0;
        repeat (RL + 3) begin
            @(posedge clk);
            #2;
            rv_cnt += int'(bus.rvalid);
        end
        chk("midrst_no_rvalid", rv_cnt, 0);
        access_wait(1'b0, 3'b010, 12'h030, 32'h0, dv, ev, lat);
        chk("mem_survives_rst", dv, 32'h1234AAAA);

        for (int i = 0; i < 300; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_access(rw, rf3, 12'($urandom_range(0, 255)), $urandom);
        end

        repeat (RL + 4) @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
